// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: FSM state encoding,
// line levels, frame geometry and the decoder's address map.
package uart_pkg;

    // Both the transmitter and receiver walk the same four phases of an 8N1 frame.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam int   DATA_BITS       = 8;

    // Addresses the peripheral decoder uses to select this block.
    localparam logic [31:0] UART_TX_ADDR    = 32'h1001_002C;
    localparam logic [31:0] UART_RX_ADDR    = 32'h1001_0030;
    localparam logic [31:0] UART_BUSY_ADDR  = 32'h1001_0034;
    localparam logic [31:0] UART_READY_ADDR = 32'h1001_0038;

endpackage

// File: rtl/uart_bus_responder_if.sv
// Bus-side signals between the peripheral decoder (master) and the UART
// responder (slave).
//
// Handshake: a transmit request is valid while enable_SendTx & MemWrite is
// high; the responder is ready only while UART_BUSY is low. A request is
// taken on its rising edge when ready, and a request that is held, or that
// arrives while busy, is dropped rather than queued. reset_UART_READY is a
// level acknowledge for the received byte and never blocks.
interface uart_bus_responder_if;
    logic        enable_SendTx;
    logic        MemWrite;
    logic [31:0] HWDATA;
    logic        reset_UART_READY;
    logic [7:0]  HRDATA_UART;
    logic        UART_BUSY;
    logic        UART_READY;
    logic        FRAME_ERR;

    modport master (
        output enable_SendTx, MemWrite, HWDATA, reset_UART_READY,
        input  HRDATA_UART, UART_BUSY, UART_READY, FRAME_ERR
    );

    modport slave (
        input  enable_SendTx, MemWrite, HWDATA, reset_UART_READY,
        output HRDATA_UART, UART_BUSY, UART_READY, FRAME_ERR
    );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last
// count, or on the last count of half a period when half is set (used to
// land on the middle of a start bit). Held at zero while clear is high.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic half,
    output logic tick
);

    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] FULL_LAST = W'(CLKS_PER_BIT - 1);
    localparam logic [W-1:0] HALF_LAST = W'(CLKS_PER_BIT / 2 - 1);

    logic [W-1:0] count;

    assign tick = ~clear & (count == (half ? HALF_LAST : FULL_LAST));

    // Free-run within a bit, reload to zero at every bit boundary.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_bus_responder.sv
// Memory-mapped 8N1 UART: serialises a byte written to UART_TX onto tx and
// deserialises frames from rx into HRDATA_UART with BUSY/READY/FRAME_ERR
// status for the decoder's read mux. Transmitter and receiver are independent.
module uart_bus_responder
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                   clk,
    input  logic                   reset,
    uart_bus_responder_if.slave    bus,
    input  logic                   rx,
    output logic                   tx,
    output uart_state_e            tx_state_dbg,
    output uart_state_e            rx_state_dbg
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    // ---------------- transmitter ----------------
    uart_state_e tx_state, tx_state_next;
    logic [2:0]  tx_bit_idx, tx_bit_idx_next;
    logic [7:0]  tx_shift;
    logic        tx_tick;
    logic        tx_d;
    logic        tx_busy_q;
    logic        send_req, send_req_q, tx_accept;
    logic        unused_hwdata_hi;

    assign send_req         = bus.enable_SendTx & bus.MemWrite;
    assign tx_accept        = send_req & ~send_req_q & (tx_state == ST_IDLE);
    assign unused_hwdata_hi = ^bus.HWDATA[31:8];

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
        .clk   (clk),
        .reset (reset),
        .clear (tx_state == ST_IDLE),
        .half  (1'b0),
        .tick  (tx_tick)
    );

    // TX next state; the line level is derived from the state being entered
    // so the registered tx lines up with the state change.
    always_comb begin
        tx_state_next   = tx_state;
        tx_bit_idx_next = tx_bit_idx;
        tx_d            = UART_IDLE_LEVEL;
        case (tx_state)
            ST_IDLE: begin
                if (tx_accept) begin
                    tx_state_next   = ST_START;
                    tx_bit_idx_next = '0;
                end
            end
            ST_START: begin
                if (tx_tick) begin
                    tx_state_next   = ST_DATA;
                    tx_bit_idx_next = '0;
                end
            end
            ST_DATA: begin
                if (tx_tick) begin
                    if (tx_bit_idx == LAST_BIT) begin
                        tx_state_next = ST_STOP;
                    end else begin
                        tx_bit_idx_next = tx_bit_idx + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (tx_tick) begin
                    tx_state_next = ST_IDLE;
                end
            end
            default: tx_state_next = ST_IDLE;
        endcase
        case (tx_state_next)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = tx_shift[tx_bit_idx_next];
            default:  tx_d = UART_IDLE_LEVEL;
        endcase
    end

    // TX state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state   <= ST_IDLE;
            tx_bit_idx <= '0;
        end else begin
            tx_state   <= tx_state_next;
            tx_bit_idx <= tx_bit_idx_next;
        end
    end

    // TX datapath: byte capture on acceptance, registered line and busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx         <= UART_IDLE_LEVEL;
            tx_busy_q  <= 1'b0;
            tx_shift   <= '0;
            send_req_q <= 1'b0;
        end else begin
            send_req_q <= send_req;
            tx         <= tx_d;
            tx_busy_q  <= (tx_state_next != ST_IDLE);
            if (tx_accept) begin
                tx_shift <= bus.HWDATA[7:0];
            end
        end
    end

    // ---------------- receiver ----------------
    logic [1:0]  rx_sync;
    logic        rx_s;
    uart_state_e rx_state, rx_state_next;
    logic [2:0]  rx_bit_idx, rx_bit_idx_next;
    logic [7:0]  rx_shift;
    logic        rx_tick;
    logic        rx_shift_en, rx_done_ok, rx_done_err;
    logic [7:0]  rx_data_q;
    logic        rx_ready_q, frame_err_q;

    assign rx_s = rx_sync[1];

    // Two-flop synchroniser for the asynchronous serial input.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync <= {2{UART_IDLE_LEVEL}};
        end else begin
            rx_sync <= {rx_sync[0], rx};
        end
    end

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
        .clk   (clk),
        .reset (reset),
        .clear (rx_state == ST_IDLE),
        .half  (rx_state == ST_START),
        .tick  (rx_tick)
    );

    // RX next state and sampling strobes; every sample is taken at mid-bit.
    always_comb begin
        rx_state_next   = rx_state;
        rx_bit_idx_next = rx_bit_idx;
        rx_shift_en     = 1'b0;
        rx_done_ok      = 1'b0;
        rx_done_err     = 1'b0;
        case (rx_state)
            ST_IDLE: begin
                if (!rx_s) begin
                    rx_state_next = ST_START;
                end
            end
            ST_START: begin
                if (rx_tick) begin
                    if (rx_s) begin
                        rx_state_next = ST_IDLE;
                    end else begin
                        rx_state_next   = ST_DATA;
                        rx_bit_idx_next = '0;
                    end
                end
            end
            ST_DATA: begin
                if (rx_tick) begin
                    rx_shift_en = 1'b1;
                    if (rx_bit_idx == LAST_BIT) begin
                        rx_state_next = ST_STOP;
                    end else begin
                        rx_bit_idx_next = rx_bit_idx + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (rx_tick) begin
                    rx_state_next = ST_IDLE;
                    rx_done_ok    = rx_s;
                    rx_done_err   = ~rx_s;
                end
            end
            default: rx_state_next = ST_IDLE;
        endcase
    end

    // RX state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state   <= ST_IDLE;
            rx_bit_idx <= '0;
        end else begin
            rx_state   <= rx_state_next;
            rx_bit_idx <= rx_bit_idx_next;
        end
    end

    // RX datapath: LSB-first shift, byte hand-off and status flags. A byte
    // completing in the same cycle as the acknowledge keeps READY set.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_shift    <= '0;
            rx_data_q   <= '0;
            rx_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (rx_shift_en) begin
                rx_shift <= {rx_s, rx_shift[7:1]};
            end
            if (rx_done_ok) begin
                rx_data_q  <= rx_shift;
                rx_ready_q <= 1'b1;
            end else if (bus.reset_UART_READY) begin
                rx_ready_q  <= 1'b0;
                frame_err_q <= 1'b0;
            end
            if (rx_done_err) begin
                frame_err_q <= 1'b1;
            end
        end
    end

    assign bus.HRDATA_UART = rx_data_q;
    assign bus.UART_BUSY   = tx_busy_q;
    assign bus.UART_READY  = rx_ready_q;
    assign bus.FRAME_ERR   = frame_err_q;
    assign tx_state_dbg    = tx_state;
    assign rx_state_dbg    = rx_state;

endmodule

// File: tb/tb_uart_bus_responder.sv
// Bench for uart_bus_responder at 16 clocks per bit: directed scenarios plus
// randomised bytes checked against a frame-level model of 8N1 behaviour.
module tb_uart_bus_responder;
    import uart_pkg::*;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_drv = 1'b1;
    logic        loop_en = 1'b0;
    logic        rx_line;
    logic        tx;
    uart_state_e tx_state_dbg;
    uart_state_e rx_state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rise_cyc = -1000;
    logic ready_prev = 1'b0;
    logic [7:0] exp_q[$];

    uart_bus_responder_if bus();

    assign rx_line = loop_en ? tx : rx_drv;

    uart_bus_responder #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .rx           (rx_line),
        .tx           (tx),
        .tx_state_dbg (tx_state_dbg),
        .rx_state_dbg (rx_state_dbg)
    );

    // ---------------- clock / cycle counter / READY rise monitor ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.UART_READY === 1'b1 && ready_prev !== 1'b1) rise_cyc <= cyc;
        ready_prev <= bus.UART_READY;
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_write(input logic [7:0] data);
        logic [31:0] w;
        w = $urandom;
        w[7:0] = data;
        @(negedge clk);
        bus.HWDATA = w;
        bus.enable_SendTx = 1'b1;
        bus.MemWrite = 1'b1;
        @(negedge clk);
        bus.enable_SendTx = 1'b0;
        bus.MemWrite = 1'b0;
    endtask

    task automatic wait_tx_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12 * CPB && !ok; i++) begin
            @(negedge clk);
            if (bus.UART_BUSY === 1'b0) ok = 1'b1;
        end
    endtask

    // Drive one 8N1 frame on rx, LSB first; start_cyc is the cycle count at
    // the falling edge of the start bit.
    task automatic drive_rx_frame(input logic [7:0] data, input logic stop_bit, output int start_cyc);
        @(negedge clk);
        start_cyc = cyc;
        rx_drv = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = data[i];
            repeat (CPB) @(negedge clk);
        end
        rx_drv = stop_bit;
        repeat (CPB) @(negedge clk);
        rx_drv = 1'b1;
    endtask

    // Send one byte through the bus and check tx/BUSY every cycle against the
    // ideal frame: start 0, data LSB first, stop 1, each CPB cycles long.
    // The request stays high for 'hold' cycles; at cycle 'inject_at' a second
    // one-cycle request carrying inject_data is issued (must be ignored).
    task automatic tx_frame(input logic [7:0] data, input int hold, input int inject_at,
                            input logic [7:0] inject_data, input string name);
        logic [31:0] w;
        logic        req;
        logic        exp_bit;
        int          idx;
        w = $urandom;
        w[7:0] = data;
        @(negedge clk);
        bus.HWDATA = w;
        bus.enable_SendTx = 1'b1;
        bus.MemWrite = 1'b1;
        for (int k = 1; k <= 10 * CPB; k++) begin
            @(negedge clk);
            idx = (k - 1) / CPB;
            if (idx == 0) exp_bit = 1'b0;
            else if (idx == 9) exp_bit = 1'b1;
            else exp_bit = data[idx-1];
            checks++;
            if (tx !== exp_bit || bus.UART_BUSY !== 1'b1) begin
                errors++;
                $display("FAIL %s frame cycle %0d: tx=%b busy=%b, expected tx=%b busy=1",
                         name, k, tx, bus.UART_BUSY, exp_bit);
            end
            req = (k < hold) || (k == inject_at);
            if (k == inject_at) bus.HWDATA = {24'h0, inject_data};
            bus.enable_SendTx = req;
            bus.MemWrite = req;
        end
        bus.enable_SendTx = 1'b0;
        bus.MemWrite = 1'b0;
        for (int k = 1; k <= 2 * CPB; k++) begin
            @(negedge clk);
            checks++;
            if (tx !== 1'b1 || bus.UART_BUSY !== 1'b0) begin
                errors++;
                $display("FAIL %s after-frame cycle %0d: tx=%b busy=%b, expected tx=1 busy=0",
                         name, k, tx, bus.UART_BUSY);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || bus.UART_BUSY !== 1'b0 || bus.UART_READY !== 1'b0 ||
            bus.HRDATA_UART !== 8'h00 || bus.FRAME_ERR !== 1'b0 || tx_state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_values: tx=%b busy=%b ready=%b data=%h ferr=%b, expected 1 0 0 00 0",
                     tx, bus.UART_BUSY, bus.UART_READY, bus.HRDATA_UART, bus.FRAME_ERR);
        end
        reset = 1'b0;
        pulse_write(8'h00);
        repeat (39) @(negedge clk);
        checks++;
        if (tx !== 1'b0 || bus.UART_BUSY !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_tx_pre: tx=%b busy=%b, expected tx=0 busy=1", tx, bus.UART_BUSY);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || bus.UART_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_tx: tx=%b busy=%b, expected tx=1 busy=0", tx, bus.UART_BUSY);
        end
        reset = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || bus.UART_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_tx_after: tx=%b busy=%b, expected tx=1 busy=0", tx, bus.UART_BUSY);
        end
    endtask

    task automatic test_tx();
        tx_frame(8'hA5, 1, -1, 8'h00, "tx_a5");
    endtask

    task automatic test_tx_ignore();
        tx_frame(8'hA5, 1, 5 * CPB, 8'h3C, "tx_ignore_busy");
        tx_frame(8'hC3, 40, -1, 8'h00, "tx_hold40");
        // A store to another address or a select without a store starts nothing.
        @(negedge clk);
        bus.MemWrite = 1'b1;
        @(negedge clk);
        bus.MemWrite = 1'b0;
        bus.enable_SendTx = 1'b1;
        @(negedge clk);
        bus.enable_SendTx = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.UART_BUSY !== 1'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL tx_partial_select: busy=%b tx=%b, expected busy=0 tx=1", bus.UART_BUSY, tx);
        end
    endtask

    task automatic test_rx();
        int s;
        drive_rx_frame(8'h5A, 1'b1, s);
        checks++;
        if (rise_cyc - s < 9 * CPB + CPB / 4 || rise_cyc - s > 9 * CPB + 3 * CPB / 4 + 2) begin
            errors++;
            $display("FAIL rx_ready_timing: READY rose %0d cycles after start edge, expected mid-stop (%0d..%0d)",
                     rise_cyc - s, 9 * CPB + CPB / 4, 9 * CPB + 3 * CPB / 4 + 2);
        end
        checks++;
        if (bus.UART_READY !== 1'b1 || bus.HRDATA_UART !== 8'h5A || bus.FRAME_ERR !== 1'b0) begin
            errors++;
            $display("FAIL rx_5a: ready=%b data=%h ferr=%b, expected ready=1 data=5a ferr=0",
                     bus.UART_READY, bus.HRDATA_UART, bus.FRAME_ERR);
        end
        bus.reset_UART_READY = 1'b1;
        @(negedge clk);
        bus.reset_UART_READY = 1'b0;
        checks++;
        if (bus.UART_READY !== 1'b0 || bus.HRDATA_UART !== 8'h5A) begin
            errors++;
            $display("FAIL rx_clear: ready=%b data=%h, expected ready=0 data=5a", bus.UART_READY, bus.HRDATA_UART);
        end
    endtask

    task automatic test_rx_errors();
        int s;
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        checks++;
        if (bus.UART_READY !== 1'b0 || bus.FRAME_ERR !== 1'b0 || bus.HRDATA_UART !== 8'h5A ||
            rx_state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL rx_glitch: ready=%b ferr=%b data=%h, expected ready=0 ferr=0 data=5a and idle",
                     bus.UART_READY, bus.FRAME_ERR, bus.HRDATA_UART);
        end
        drive_rx_frame(8'h33, 1'b0, s);
        repeat (CPB) @(negedge clk);
        checks++;
        if (bus.FRAME_ERR !== 1'b1 || bus.UART_READY !== 1'b0 || bus.HRDATA_UART !== 8'h5A) begin
            errors++;
            $display("FAIL rx_frame_err: ferr=%b ready=%b data=%h, expected ferr=1 ready=0 data=5a",
                     bus.FRAME_ERR, bus.UART_READY, bus.HRDATA_UART);
        end
    endtask

    task automatic test_loopback();
        bit found;
        bit ok;
        loop_en = 1'b1;
        bus.reset_UART_READY = 1'b1;
        pulse_write(8'hFF);
        found = 1'b0;
        for (int i = 0; i < 14 * CPB && !found; i++) begin
            @(negedge clk);
            if (bus.UART_READY === 1'b1) found = 1'b1;
        end
        bus.reset_UART_READY = 1'b0;
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL loop_set_wins: READY never rose with acknowledge held, expected ready=1");
        end else if (bus.HRDATA_UART !== 8'hFF || bus.FRAME_ERR !== 1'b0) begin
            errors++;
            $display("FAIL loop_set_wins: data=%h ferr=%b, expected data=ff ferr=0", bus.HRDATA_UART, bus.FRAME_ERR);
        end
        @(negedge clk);
        checks++;
        if (bus.UART_READY !== 1'b1) begin
            errors++;
            $display("FAIL loop_ready_hold: ready=%b, expected 1", bus.UART_READY);
        end
        wait_tx_idle(ok);
        pulse_write(8'h01);
        wait_tx_idle(ok);
        repeat (CPB) @(negedge clk);
        checks++;
        if (!ok || bus.HRDATA_UART !== 8'h01 || bus.UART_READY !== 1'b1) begin
            errors++;
            $display("FAIL loop_overrun: idle=%0d data=%h ready=%b, expected idle=1 data=01 ready=1",
                     ok, bus.HRDATA_UART, bus.UART_READY);
        end
        loop_en = 1'b0;
    endtask

    task automatic test_random();
        bit ok;
        int s;
        logic [7:0] b;
        logic [7:0] exp;
        // Bit-exact transmit of random bytes with random hold and a stray write.
        for (int n = 0; n < 3; n++) begin
            tx_frame(8'($urandom), $urandom_range(1, 30), $urandom_range(32, 150), 8'($urandom), "tx_random");
        end
        // Random received frames, unread between them (overrun keeps READY).
        for (int n = 0; n < 4; n++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            drive_rx_frame(b, 1'b1, s);
            exp = exp_q.pop_front();
            checks++;
            if (bus.HRDATA_UART !== exp || bus.UART_READY !== 1'b1) begin
                errors++;
                $display("FAIL rx_random %0d: data=%h ready=%b, expected data=%h ready=1",
                         n, bus.HRDATA_UART, bus.UART_READY, exp);
            end
        end
        // Random loopback with simultaneous TX and RX activity.
        loop_en = 1'b1;
        for (int n = 0; n < 4; n++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            wait_tx_idle(ok);
            pulse_write(b);
            wait_tx_idle(ok);
            repeat (CPB / 2) @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || bus.HRDATA_UART !== exp || bus.UART_READY !== 1'b1) begin
                errors++;
                $display("FAIL loop_random %0d: idle=%0d data=%h ready=%b, expected idle=1 data=%h ready=1",
                         n, ok, bus.HRDATA_UART, bus.UART_READY, exp);
            end
        end
        loop_en = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.enable_SendTx = 1'b0;
        bus.MemWrite = 1'b0;
        bus.HWDATA = 32'h0;
        bus.reset_UART_READY = 1'b0;
        test_reset();
        test_tx();
        test_tx_ignore();
        test_rx();
        test_rx_errors();
        test_loopback();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_bus_responder.md
Name: uart_bus_responder

Overview:
Memory-mapped UART peripheral that answers the core's peripheral decoder. It serves the UART_TX, UART_RX, UART_BUSY and UART_READY addresses (0x1001002C / 30 / 34 / 38). It serialises a written byte as 8N1 on tx, deserialises 8N1 frames from rx, and exposes the received byte plus BUSY/READY status bits for the decoder to place on the read-data bus.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 4.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable_SendTx  in  1  decoder select for the UART_TX address
MemWrite  in  1  store strobe from the core
HWDATA  in  32  write data; only [7:0] is used
reset_UART_READY  in  1  level; clears READY (asserted by the decoder on UART_RX reads)
rx  in  1  asynchronous serial input, idle high
tx  out  1  serial output, idle high
HRDATA_UART  out  8  last correctly received byte
UART_BUSY  out  1  transmitter active
UART_READY  out  1  unread byte available
FRAME_ERR  out  1  sticky: stop bit sampled low

Behaviour:
- One clock domain. Reset is synchronous, active-high, and overrides everything, including mid-frame.
- Reset values: tx=1, UART_BUSY=0, UART_READY=0, HRDATA_UART=0x00, FRAME_ERR=0. Both FSMs go to IDLE, bit timers to 0, rx synchroniser to 1.
- TX request: send_req = enable_SendTx & MemWrite. It is accepted only in TX IDLE.
  - On acceptance, HWDATA[7:0] is latched into the shift register.
  - Requests while busy are ignored; no queueing.
  - A request held for several cycles while idle starts one frame. Re-arm only after the request deasserts (edge-qualified).
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - Each non-IDLE state lasts CLKS_PER_BIT cycles.
  - DATA sends 8 bits, LSB first, with a 3-bit index; STOP drives 1.
  - tx is registered: tx=0 first appears the cycle after acceptance.
  - UART_BUSY is registered, = (state != IDLE). It rises the cycle after acceptance and falls after exactly 10*CLKS_PER_BIT cycles.
- RX input: passes through a 2-flop synchroniser before any use.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a synchronised rx==0 enters START.
  - START: sample at CLKS_PER_BIT/2. If rx==1 it is a glitch: return to IDLE, no flags change.
  - DATA: sample 8 bits at successive mid-bit points (every CLKS_PER_BIT), LSB first.
  - STOP: sample at mid-bit.
    - If 1: HRDATA_UART <= shifted byte and UART_READY <= 1 on the same edge.
    - If 0: FRAME_ERR <= 1; HRDATA_UART and UART_READY unchanged.
    - Either way return to IDLE immediately, giving half-bit margin for back-to-back frames.
- UART_READY priority:
  - Set (byte completion) wins over reset_UART_READY in the same cycle.
  - Otherwise reset_UART_READY=1 clears READY and FRAME_ERR.
  - HRDATA_UART holds its value after clear.
- Overrun: a new byte completing while READY=1 overwrites HRDATA_UART; READY stays 1.
- TX and RX are fully independent; simultaneous operation is permitted.
- Bit-timer wrap: each counter counts 0..CLKS_PER_BIT-1 and reloads to 0 at every bit boundary. Width is $clog2(CLKS_PER_BIT).

Decomposition:
- Package uart_pkg holds:
  - TX/RX state encodings (2-bit IDLE/START/DATA/STOP);
  - UART_IDLE_LEVEL=1'b1;
  - DATA_BITS=8;
  - the address constants 0x1001002C/30/34/38 shared with the decoder.
- One natural sub-module, uart_bit_timer, instantiated twice (TX, RX). Ports: clk, reset, clear, half (select mid-bit), tick.

Test Plan:
1. Reset, hold 5 cycles -> tx=1, UART_BUSY=0, UART_READY=0, HRDATA_UART=0x00, FRAME_ERR=0. Repeat with reset asserted mid-TX -> tx=1 and BUSY=0 on the next edge.
2. CLKS_PER_BIT=16; pulse enable_SendTx=MemWrite=1 for one cycle with HWDATA=0x000000A5 -> BUSY=1 next cycle; tx = 0, then 1,0,1,0,0,1,0,1, then 1, each bit 16 cycles; BUSY=0 exactly 160 cycles after it rose.
3. During the 0xA5 frame, issue a write of 0x3C -> ignored; the line carries only 0xA5. Holding the request high for 40 cycles while idle -> exactly one frame.
4. Drive an rx frame of 0x5A at 16 cycles/bit -> READY rises at mid-stop with HRDATA_UART=0x5A. Pulse reset_UART_READY -> READY=0 next edge, HRDATA_UART still 0x5A.
5. rx low for 4 cycles only -> no READY change. Then a frame 0x33 with stop bit 0 -> FRAME_ERR=1, READY=0, HRDATA_UART unchanged.
6. Loop tx->rx sending 0xFF; assert reset_UART_READY in the exact completion cycle -> READY=1, HRDATA_UART=0xFF. A second unread byte 0x01 overwrites -> HRDATA_UART=0x01, READY=1.
